idwt_1d1l: RTL and testbench
============================

// Module: idwt_1d1l
// PURPOSE
//  Inverse 1-D, 1-level lifting DWT. Sits directly downstream of the forward DWT_1D1L stage.
//  Consumes one (low, high) coefficient pair per transfer and rebuilds the interleaved sample
//  stream e[0], o[0], e[1], o[1], ... for one line. Uses valid/ready handshakes on both sides
//  and symmetric extension at both line ends.
// PARAMETERS
//  DATA_W   8   width of coefficients and reconstructed samples (signed two's complement)
// PORTS
//  sys_clk    in   1        clock; all state updates on posedge
//  sys_rst    in   1        asynchronous reset, active-low
//  in_valid   in   1        coefficient pair valid
//  in_ready   out  1        block accepts a pair this cycle
//  in_low     in   DATA_W   low-band coefficient L[n], signed
//  in_high    in   DATA_W   high-band coefficient H[n], signed
//  in_last    in   1        pair is the final pair (N-1) of the line
//  out_valid  out  1        out_data valid
//  out_ready  in   1        downstream accepts out_data
//  out_data   out  DATA_W   reconstructed sample, signed
//  out_last   out  1        out_data is the final sample o[N-1] of the line
// BEHAVIOUR
//  - Reset (sys_rst=0, async): state=IDLE; out_valid=0, out_data=0, out_last=0; in_ready=0
//    while reset is asserted. All internal registers (ep, hp, last_q) are cleared to 0.
//  - Math: signed, internal width DATA_W+2, >>> is arithmetic shift.
//    e[n] = L[n] - ((H[n-1] + H[n]) >>> 2), with H[-1] = H[0].
//    o[n] = H[n] + ((e[n] + e[n+1]) >>> 1), with e[N] = e[N-1], giving o[N-1] = H[N-1] + e[N-1].
//    ep and hp are held at full internal width. out_data is the DATA_W LSBs of the result
//    (wraps, no saturation).
//  - Output slot: one register. slot_free = !out_valid | out_ready. A transfer occurs when
//    out_valid & out_ready; out_valid drops next cycle unless the slot is reloaded.
//  - in_ready = (state==IDLE | state==WAIT) & slot_free. A pair is accepted when
//    in_valid & in_ready.
//  - FSM (states IDLE, WAIT, EMIT_E, TAIL):
//    IDLE  : accept pair 0 -> load out=e[0]; ep=e[0], hp=H[0]; last_q=in_last
//            -> TAIL if in_last, else WAIT.
//    WAIT  : accept pair n -> compute e[n] from hp, H[n] and L[n]; load out=o[n-1] using
//            hp, ep, e[n]; then ep=e[n], hp=H[n], last_q=in_last -> EMIT_E.
//    EMIT_E: when slot_free -> load out=ep (e[n]) -> TAIL if last_q, else WAIT.
//    TAIL  : when slot_free -> load out=hp+ep with out_last=1 -> IDLE.
//  - out_last is 1 only with o[N-1]; all other loads set out_last=0.
//  - Latency: e[0] is valid the cycle after pair 0 is accepted. Peak rate: 1 pair per 2 cycles.
//  - Backpressure: while out_valid & !out_ready, out_data and out_last hold stable and the
//    FSM does not advance.
//  - in_last on pair 0 gives a 2-sample line.
//  - The first pair of a new line is accepted in IDLE, which is re-entered the cycle after
//    o[N-1] is loaded. No bubble is needed beyond the slot rule.
//  - in_low/in_high are ignored unless a pair is accepted. Reset mid-line discards the partial
//    line; the next accepted pair is treated as pair 0.
// TESTING
//  1 Single pair L=10, H=4, last=1 -> out 8, then 12 with out_last=1; back to IDLE.
//  2 Line (10,4), (20,-6), (30,2 last), out_ready=1 -> out 8, 18, 21, 20, 31, 33;
//    out_last only on 33.
//  3 Repeat test 2 with out_ready=0 for 5 cycles after the 2nd output -> 18 held stable,
//    in_ready=0, identical sequence afterwards.
//  4 Wrap: L=127, H=-128, last -> out 0xBF (-65), then 0x3F (63); internal e[0]=191 is not
//    truncated.
//  5 Reset pulse after 2 pairs of test 2 -> out_valid=0 immediately (async); after release,
//    test 1 stimulus yields 8, 12.
//  6 Two back-to-back lines (test 2 then test 1) with in_valid held high -> 8, 18, 21, 20,
//    31, 33, 8, 12 with correct out_last markers.

Source files
------------

// File: rtl/idwt_1d1l.sv
// idwt_1d1l: inverse 1-D, 1-level lifting DWT.
// Rebuilds the interleaved sample stream e[0], o[0], e[1], o[1], ... of one line
// from (low, high) coefficient pairs, with symmetric extension at both line ends.
// One output register; valid/ready handshakes on both sides.

module idwt_1d1l #(
  parameter int DATA_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_low,
  input  logic signed [DATA_W-1:0] in_high,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_last
);

  // Internal width leaves headroom so e[n] and the odd-sample sums never overflow.
  localparam int W = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    EMIT_E = 2'd2,
    TAIL   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ep holds the most recent even sample, hp the most recent high coefficient.
  logic signed [W-1:0] ep_q, ep_d;
  logic signed [W-1:0] hp_q, hp_d;
  logic                last_q, last_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic slot_free;
  logic accept;

  logic signed [W-1:0] l_ext;
  logic signed [W-1:0] h_ext;
  logic signed [W-1:0] h_sum_first;
  logic signed [W-1:0] e_first;
  logic signed [W-1:0] h_sum_next;
  logic signed [W-1:0] e_next;
  logic signed [W-1:0] e_sum;
  logic signed [W-1:0] o_prev;
  logic signed [W-1:0] o_tail;
  logic                unused_upper_bits;

  assign l_ext = {{(W-DATA_W){in_low[DATA_W-1]}}, in_low};
  assign h_ext = {{(W-DATA_W){in_high[DATA_W-1]}}, in_high};

  // The output slot can take a new value when empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = sys_rst && ((state_q == IDLE) || (state_q == WAIT)) && slot_free;
  assign accept    = in_valid && in_ready;

  // Lifting arithmetic: first even sample mirrors H[-1]=H[0]; later ones use the held hp.
  always_comb begin
    h_sum_first = h_ext + h_ext;
    e_first     = l_ext - (h_sum_first >>> 2);
    h_sum_next  = hp_q + h_ext;
    e_next      = l_ext - (h_sum_next >>> 2);
    e_sum       = ep_q + e_next;
    o_prev      = hp_q + (e_sum >>> 1);
    o_tail      = hp_q + ep_q;
  end

  // Only the low DATA_W bits of the odd samples reach the output; the rest wrap away.
  assign unused_upper_bits = ^{o_prev[W-1:DATA_W], o_tail[W-1:DATA_W]};

  // Next-state and output-slot logic; the slot only changes when it is free.
  always_comb begin
    state_d     = state_q;
    ep_d        = ep_q;
    hp_d        = hp_q;
    last_d      = last_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = e_first[DATA_W-1:0];
          out_last_d  = 1'b0;
          ep_d        = e_first;
          hp_d        = h_ext;
          last_d      = in_last;
          state_d     = in_last ? TAIL : WAIT;
        end
      end
      WAIT: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = o_prev[DATA_W-1:0];
          out_last_d  = 1'b0;
          ep_d        = e_next;
          hp_d        = h_ext;
          last_d      = in_last;
          state_d     = EMIT_E;
        end
      end
      EMIT_E: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = ep_q[DATA_W-1:0];
          out_last_d  = 1'b0;
          state_d     = last_q ? TAIL : WAIT;
        end
      end
      TAIL: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = o_tail[DATA_W-1:0];
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any partial line.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      ep_q        <= '0;
      hp_q        <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ep_q        <= ep_d;
      hp_q        <= hp_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_idwt_1d1l.sv
// Testbench for idwt_1d1l: directed lines, an arithmetic reference model of the
// inverse lifting transform, and a per-cycle output compare against that model.

module tb_idwt_1d1l;

  localparam int DATA_W = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
  } exp_t;

  logic                     sys_clk;
  logic                     sys_rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_low;
  logic signed [DATA_W-1:0] in_high;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic        [DATA_W-1:0] out_data;
  logic                     out_last;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_xfer = 0;
  exp_t exp_q[$];

  idwt_1d1l #(.DATA_W(DATA_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_low   (in_low),
    .in_high  (in_high),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One comparison: counts it, reports a failure line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Even sample from the spec's update step.
  function automatic int evenCoef(input int l, input int hprev, input int h);
    return l - ((hprev + h) >>> 2);
  endfunction

  // Reference model: full interleaved output of one line, wrapped to DATA_W bits.
  function automatic void modelLine(input int ls[$], input int hs[$], output exp_t res[$]);
    int   n;
    int   e[$];
    int   enext;
    int   o;
    exp_t item;
    n = ls.size();
    res.delete();
    for (int i = 0; i < n; i++)
      e.push_back(evenCoef(ls[i], (i == 0) ? hs[0] : hs[i-1], hs[i]));
    for (int i = 0; i < n; i++) begin
      enext     = (i == n - 1) ? e[i] : e[i+1];
      o         = hs[i] + ((e[i] + enext) >>> 1);
      item.data = DATA_W'(e[i]);
      item.last = 1'b0;
      res.push_back(item);
      item.data = DATA_W'(o);
      item.last = (i == n - 1);
      res.push_back(item);
    end
  endfunction

  function automatic void pushLine(input int ls[$], input int hs[$]);
    exp_t r[$];
    modelLine(ls, hs, r);
    foreach (r[i]) exp_q.push_back(r[i]);
  endfunction

  // Present one pair and wait (bounded) until it is accepted; in_valid stays high.
  task automatic applyStimulus(input int l, input int h, input bit last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_low   = DATA_W'(l);
    in_high  = DATA_W'(h);
    in_last  = last;
    @(negedge sys_clk);
    while (!in_ready && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", 0, 1);
    @(posedge sys_clk);
    #1;
  endtask

  // Wait (bounded) until every expected sample has been seen.
  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge sys_clk);
      guard++;
    end
    checkOutput(name, exp_q.size(), 0);
    @(posedge sys_clk);
    #1;
  endtask

  // Per-cycle compare: every pending transfer against the model, plus hold stability.
  logic [DATA_W-1:0] held_data;
  logic              held_last;
  bit                held_valid = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && out_valid) begin
        checkOutput("hold_data", int'(out_data), int'(held_data));
        checkOutput("hold_last", int'(out_last), int'(held_last));
      end
      held_valid = 1'b0;
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", int'($signed(out_data)), 9999);
        end else begin
          checkOutput("out_data", int'($signed(out_data)), int'($signed(exp_q[0].data)));
          checkOutput("out_last", int'(out_last), int'(exp_q[0].last));
          void'(exp_q.pop_front());
        end
      end else if (out_valid) begin
        held_valid = 1'b1;
        held_data  = out_data;
        held_last  = out_last;
      end
    end
  end

  exp_t pin_r[$];
  int   base;
  int   guard;

  initial begin
    sys_rst   = 1'b0;
    in_valid  = 1'b0;
    in_low    = '0;
    in_high   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Pin the model with hand-computed values.
    modelLine('{10, 20, 30}, '{4, -6, 2}, pin_r);
    checkOutput("pin_t2_len", pin_r.size(), 6);
    checkOutput("pin_t2_o0", int'($signed(pin_r[1].data)), 18);
    checkOutput("pin_t2_e1", int'($signed(pin_r[2].data)), 21);
    checkOutput("pin_t2_o1", int'($signed(pin_r[3].data)), 20);
    checkOutput("pin_t2_o2", int'($signed(pin_r[5].data)), 33);
    checkOutput("pin_t2_last", int'(pin_r[5].last), 1);
    modelLine('{127}, '{-128}, pin_r);
    checkOutput("pin_t4_e0", int'(pin_r[0].data), 'hBF);
    checkOutput("pin_t4_o0", int'(pin_r[1].data), 'h3F);
    checkOutput("pin_t4_e0_full", evenCoef(127, -128, -128), 191);

    // Reset state.
    #12;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("idle_in_ready", int'(in_ready), 1);

    // Test 1: single pair.
    $display("[TB] test 1: single pair");
    pushLine('{10}, '{4});
    applyStimulus(10, 4, 1'b1);
    in_valid = 1'b0;
    waitDrain("t1_drain");
    checkOutput("t1_back_idle", int'(in_ready), 1);

    // Test 2: three-pair line.
    $display("[TB] test 2: three-pair line");
    pushLine('{10, 20, 30}, '{4, -6, 2});
    applyStimulus(10, 4, 1'b0);
    applyStimulus(20, -6, 1'b0);
    applyStimulus(30, 2, 1'b1);
    in_valid = 1'b0;
    waitDrain("t2_drain");

    // Test 3: backpressure on the second output.
    $display("[TB] test 3: backpressure");
    pushLine('{10, 20, 30}, '{4, -6, 2});
    base = n_xfer;
    fork
      begin
        applyStimulus(10, 4, 1'b0);
        applyStimulus(20, -6, 1'b0);
        applyStimulus(30, 2, 1'b1);
        in_valid = 1'b0;
      end
      begin
        guard = 0;
        do begin
          @(posedge sys_clk);
          #1;
          guard++;
        end while (!(n_xfer == base + 1 && out_valid) && guard < 100);
        checkOutput("t3_stall_found", int'(guard < 100), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge sys_clk);
          checkOutput("t3_stall_data", int'($signed(out_data)), 18);
          checkOutput("t3_stall_in_ready", int'(in_ready), 0);
        end
        @(posedge sys_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("t3_drain");

    // Test 4: wrap of the even sample without internal truncation.
    $display("[TB] test 4: wrap");
    pushLine('{127}, '{-128});
    applyStimulus(127, -128, 1'b1);
    in_valid = 1'b0;
    waitDrain("t4_drain");

    // Test 5: reset mid-line, then a fresh single-pair line.
    $display("[TB] test 5: reset mid-line");
    pushLine('{10, 20, 30}, '{4, -6, 2});
    applyStimulus(10, 4, 1'b0);
    applyStimulus(20, -6, 1'b0);
    in_valid = 1'b0;
    sys_rst  = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("t5_async_valid", int'(out_valid), 0);
    checkOutput("t5_in_ready", int'(in_ready), 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    pushLine('{10}, '{4});
    applyStimulus(10, 4, 1'b1);
    in_valid = 1'b0;
    waitDrain("t5_drain");

    // Test 6: two lines back to back with in_valid held high.
    $display("[TB] test 6: back-to-back lines");
    pushLine('{10, 20, 30}, '{4, -6, 2});
    pushLine('{10}, '{4});
    applyStimulus(10, 4, 1'b0);
    applyStimulus(20, -6, 1'b0);
    applyStimulus(30, 2, 1'b1);
    applyStimulus(10, 4, 1'b1);
    in_valid = 1'b0;
    waitDrain("t6_drain");

    repeat (3) @(negedge sys_clk);
    checkOutput("final_idle_valid", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
